mcht_rx_dec: RTL



---
 rtl/mcht_pkg.sv | 37 +++
 rtl/mcht_rx_sync.sv | 92 +++++++++
 rtl/mcht_rx_dec.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mcht_pkg.sv
// -----------------------------------------------------------------------------
// mcht_pkg
// Definitions shared by the MCHT receive path:
//   - mcht_rx_state_t : decoder FSM states (IDLE, DATA, GAP_WAIT)
//   - MCHT_RISE_BIT / MCHT_FALL_BIT : Manchester bit convention
//       '0' is a high->low mid-bit transition, '1' is low->high
//   - mcht_blank / mcht_tmo / mcht_gap : timing windows derived from the
//       half-bit length in clocks
// -----------------------------------------------------------------------------
package mcht_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DATA     = 2'd1,
    GAP_WAIT = 2'd2
  } mcht_rx_state_t;

  // Data value carried by a mid-bit edge of each polarity.
  localparam logic MCHT_RISE_BIT = 1'b1;
  localparam logic MCHT_FALL_BIT = 1'b0;

  // Edges closer than this to the previous mid-bit edge are bit boundaries.
  function automatic int mcht_blank(input int half_bit);
    return (3 * half_bit) / 2;
  endfunction

  // Latest acceptable position of a mid-bit edge; no edge by then is an error.
  function automatic int mcht_tmo(input int half_bit);
    return 2 * half_bit + half_bit / 2;
  endfunction

  // Consecutive high samples required before the next frame may start.
  function automatic int mcht_gap(input int half_bit);
    return 2 * half_bit;
  endfunction

endpackage

// File: rtl/mcht_rx_sync.sv
// -----------------------------------------------------------------------------
// mcht_rx_sync
// Brings the asynchronous serial line into the sampling clock domain and
// produces single-cycle rise/fall pulses plus the level they refer to.
//
// Optional build macro: MCHT_RX_GLITCH_FILT_EN
//   defined   : a 3-sample majority filter follows the synchronizer, rejecting
//               single-cycle glitches at the cost of 2 extra cycles of latency
//   undefined : the synchronizer output feeds the edge detector directly
//
// Ports
//   i_clk   in   sampling clock
//   i_rst   in   synchronous, active-high reset (line flops reset to idle high)
//   i_rxd   in   raw serial line, asynchronous to i_clk
//   o_line  out  filtered line level, aligned with o_rise/o_fall
//   o_rise  out  one-cycle pulse: line went low->high
//   o_fall  out  one-cycle pulse: line went high->low
// -----------------------------------------------------------------------------
module mcht_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rxd,
  output logic o_line,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync_p0;
  logic r_sync_p1;
  logic w_line;

  // --- stage p0/p1: two-flop synchronizer, reset to the idle-high level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync_p0 <= 1'b1;
      r_sync_p1 <= 1'b1;
    end else begin
      r_sync_p0 <= i_rxd;
      r_sync_p1 <= r_sync_p0;
    end
  end

`ifdef MCHT_RX_GLITCH_FILT_EN
  logic r_filt_p2;
  logic r_filt_p3;
  logic r_maj_p4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // --- stage p2..p4: majority of three consecutive samples, registered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_filt_p2 <= 1'b1;
      r_filt_p3 <= 1'b1;
      r_maj_p4  <= 1'b1;
    end else begin
      r_filt_p2 <= r_sync_p1;
      r_filt_p3 <= r_filt_p2;
      r_maj_p4  <= maj3(r_sync_p1, r_filt_p2, r_filt_p3);
    end
  end

  assign w_line = r_maj_p4;
`else
  assign w_line = r_sync_p1;
`endif

  logic r_line_pe;
  logic r_rise_pe;
  logic r_fall_pe;

  // --- edge-detect stage: pulses and the level are registered together so
  // the decoder sees a pulse in the same cycle as the new line level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_line_pe <= 1'b1;
      r_rise_pe <= 1'b0;
      r_fall_pe <= 1'b0;
    end else begin
      r_line_pe <= w_line;
      r_rise_pe <= w_line & ~r_line_pe;
      r_fall_pe <= ~w_line & r_line_pe;
    end
  end

  assign o_line = r_line_pe;
  assign o_rise = r_rise_pe;
  assign o_fall = r_fall_pe;

endmodule

// File: rtl/mcht_rx_dec.sv
// -----------------------------------------------------------------------------
// mcht_rx_dec
// Manchester line decoder for the MCHT receive link. Frame: idle high, start
// bit '0', pMSG_LEN data bits MSB first, return to idle high. The decoder
// locks on each mid-bit transition, rebuilds the message and offers it to the
// host through a valid/acknowledge handshake.
//
// Optional build macro: MCHT_RX_GLITCH_FILT_EN (see mcht_rx_sync); when
// defined every latency grows by 2 cycles.
//
// Parameters
//   pMSG_LEN   data bits per frame (2..32)
//   pHALF_BIT  clocks per Manchester half-bit (>= 4)
//
// Ports
//   CLK125M  in   sampling clock
//   RST      in   synchronous, active-high reset
//   RXD      in   raw serial line, asynchronous to CLK125M
//   RX_MSG   out  decoded message, stable while RX_VLD=1
//   RX_VLD   out  message available, held until acknowledged
//   RX_ACK   in   host consumes the message (ignored while RX_VLD=0)
//   RX_ERR   out  one-cycle pulse on a mid-bit timeout
//   RX_OVF   out  sticky: a frame completed while RX_VLD was still 1
// -----------------------------------------------------------------------------
module mcht_rx_dec
  import mcht_pkg::*;
#(
  parameter int pMSG_LEN  = 8,
  parameter int pHALF_BIT = 5
) (
  input  logic                CLK125M,
  input  logic                RST,
  input  logic                RXD,
  output logic [pMSG_LEN-1:0] RX_MSG,
  output logic                RX_VLD,
  input  logic                RX_ACK,
  output logic                RX_ERR,
  output logic                RX_OVF
);

  localparam int BLANK = mcht_blank(pHALF_BIT);
  localparam int TMO   = mcht_tmo(pHALF_BIT);
  localparam int GAP   = mcht_gap(pHALF_BIT);

  localparam int CNT_W = $clog2(TMO + 1);
  localparam int IDX_W = $clog2(pMSG_LEN);
  localparam int GAP_W = $clog2(GAP + 1);

  localparam logic [CNT_W-1:0] BLANK_C    = CNT_W'(BLANK);
  localparam logic [CNT_W-1:0] TMO_C      = CNT_W'(TMO);
  localparam logic [GAP_W-1:0] GAP_LAST_C = GAP_W'(GAP - 1);
  localparam logic [IDX_W-1:0] IDX_MSB_C  = IDX_W'(pMSG_LEN - 1);

  // Next value of the edge-spacing counter, saturating at the timeout.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TMO_C) ? TMO_C : v + 1'b1;
  endfunction

  logic w_line;
  logic w_rise;
  logic w_fall;

  // --- front end: synchronizer, optional filter, edge pulses
  mcht_rx_sync u_sync (
    .i_clk  (CLK125M),
    .i_rst  (RST),
    .i_rxd  (RXD),
    .o_line (w_line),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  mcht_rx_state_t      r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [GAP_W-1:0]    r_gap;
  logic [pMSG_LEN-1:0] r_shift;

  logic                w_edge;
  logic [CNT_W-1:0]    w_elapsed;
  logic                w_bit;
  logic                w_mid_edge;
  logic                w_timeout;
  logic                w_last_bit;
  logic [pMSG_LEN-1:0] w_frame;
  logic                w_can_load;

  // r_cnt is cleared on the cycle of an accepted edge, so in any later cycle
  // the number of clocks since that edge is r_cnt+1. Windows are compared
  // against this elapsed count so that a nominal edge lands at 2*pHALF_BIT.
  assign w_edge     = w_rise | w_fall;
  assign w_elapsed  = sat_inc(r_cnt);
  assign w_bit      = w_rise ? MCHT_RISE_BIT : MCHT_FALL_BIT;
  assign w_mid_edge = (r_state == DATA) && w_edge && (w_elapsed >= BLANK_C);
  assign w_timeout  = (r_state == DATA) && !w_mid_edge && (w_elapsed == TMO_C);
  assign w_last_bit = (r_idx == '0);

  // The final bit is still being written into r_shift, so splice it in here.
  assign w_frame    = {r_shift[pMSG_LEN-1:1], w_bit};

  // A pending acknowledge frees the output register in the same cycle, so a
  // simultaneous load replaces the message instead of overflowing.
  assign w_can_load = !RX_VLD || RX_ACK;

  // --- data stage: shift register, written MSB first at each mid-bit edge
  always_ff @(posedge CLK125M) begin
    if (w_mid_edge) begin
      r_shift[r_idx] <= w_bit;
    end
  end

  // --- control stage: FSM, counters and host handshake
  always_ff @(posedge CLK125M) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
      RX_MSG  <= '0;
      RX_VLD  <= 1'b0;
      RX_ERR  <= 1'b0;
      RX_OVF  <= 1'b0;
    end else begin
      RX_ERR <= 1'b0;
      r_cnt  <= w_elapsed;

      if (RX_VLD && RX_ACK) begin
        RX_VLD <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          // Only the start bit's high->low mid transition opens a frame.
          if (w_fall) begin
            r_state <= DATA;
            r_cnt   <= '0;
            r_idx   <= IDX_MSB_C;
          end
        end

        DATA: begin
          if (w_mid_edge) begin
            r_cnt <= '0;
            if (w_last_bit) begin
              r_state <= GAP_WAIT;
              r_gap   <= '0;
              // The message is handed over at the last mid-bit edge; the
              // trailing gap only guards the start of the next frame.
              if (w_can_load) begin
                RX_MSG <= w_frame;
                RX_VLD <= 1'b1;
              end else begin
                RX_OVF <= 1'b1;
              end
            end else begin
              r_idx <= r_idx - 1'b1;
            end
          end else if (w_timeout) begin
            // Partial data is simply never loaded; the next frame overwrites it.
            RX_ERR  <= 1'b1;
            r_state <= GAP_WAIT;
            r_gap   <= '0;
          end
        end

        GAP_WAIT: begin
          if (!w_line) begin
            r_gap <= '0;
          end else if (r_gap == GAP_LAST_C) begin
            r_state <= IDLE;
            r_gap   <= '0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
